// File: rtl/fp_convert_pkg.sv
// Shared definitions for the floating-point format converters.
// Holds the binary32/binary16 field widths and biases, the exponent
// rebias delta, the canonical binary16 NaN, the packed status-flag
// struct and the stage-1 payload carried between pipeline stages.
package fp_convert_pkg;

  localparam int FP32_W     = 32;
  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;
  localparam int FP32_BIAS  = 127;

  localparam int FP16_W     = 16;
  localparam int FP16_EXP_W = 5;
  localparam int FP16_MAN_W = 10;
  localparam int FP16_BIAS  = 15;

  // e16 = e32 - BIAS_DELTA (127 - 15)
  localparam int BIAS_DELTA = FP32_BIAS - FP16_BIAS;

  localparam logic [FP16_W-1:0] FP16_CANON_NAN = 16'h7E00;
  // Magnitude bits of binary16 infinity; the sign is prepended at use.
  localparam logic [FP16_W-2:0] FP16_INF_MAG   = 15'h7C00;

  // Bit order matches status_o[3:0] = {invalid, overflow, underflow, inexact}.
  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } status_t;

  // Stage-1 result. Special cases (NaN, infinity, zero, fp32 subnormal,
  // pre-rounding overflow) are fully resolved in stage 1 and carried as a
  // bypass result; everything else is rounded in stage 2.
  typedef struct packed {
    logic                  sign;
    logic                  bypass;
    logic [FP16_W-1:0]     bypass_res;
    status_t               bypass_status;
    logic                  tiny;
    logic [FP16_EXP_W-1:0] exp;
    logic [FP16_MAN_W-1:0] mant;
    logic                  guard;
    logic                  sticky;
  } s1_data_t;

endpackage

// File: rtl/fp_32_to_16_convert_stream_if.sv
// Stream bundle for the binary32 -> binary16 converter.
// Upstream side: in_valid/in_ready/operand. Downstream side:
// out_valid/out_ready/result/status.
// master: the environment (drives operands, accepts results).
// slave : the converter.
interface fp_32_to_16_convert_stream_if (
  input logic clk_i
);
  import fp_convert_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [FP32_W-1:0] operand;
  logic              out_valid;
  logic              out_ready;
  logic [FP16_W-1:0] result;
  logic [3:0]        status;

  modport master (
    input  clk_i,
    output in_valid, operand, out_ready,
    input  in_ready, out_valid, result, status
  );

  modport slave (
    input  clk_i,
    input  in_valid, operand, out_ready,
    output in_ready, out_valid, result, status
  );

endinterface

// File: rtl/fp_shift_sticky.sv
// Logical right shift with sticky collection.
// Ports:
//   data_i   - value to shift
//   shamt_i  - shift amount; amounts >= WIDTH give an all-zero data_o
//   data_o   - data_i >> shamt_i
//   sticky_o - OR of every bit shifted out of data_i
module fp_shift_sticky #(
  parameter int WIDTH = 25,
  parameter int SHW   = 10
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [SHW-1:0]   shamt_i,
  output logic [WIDTH-1:0] data_o,
  output logic             sticky_o
);

  logic [WIDTH-1:0] lost_mask;

  assign data_o    = data_i >> shamt_i;
  // Ones in every position that falls off the bottom; all ones once the
  // shift reaches WIDTH, so the sticky then covers the whole input.
  assign lost_mask = ~({WIDTH{1'b1}} << shamt_i);
  assign sticky_o  = |(data_i & lost_mask);

endmodule

// File: rtl/fp_32_to_16_convert_stream.sv
// Streaming IEEE-754 binary32 -> binary16 converter, two pipeline stages.
//   S1: unpack, classify, rebias exponent, align (subnormal shift).
//   S2: round to nearest even, detect overflow, pack.
// Ports:
//   clk_i, rst_ni          - clock, synchronous active-low reset
//   valid_i/ready_o        - operand handshake, operand_fp32_i payload
//   valid_o/ready_i        - result handshake, result_o/status_o payload
//   status_o               - {invalid, overflow, underflow, inexact}
//
// Handshake: a beat moves across a boundary on the rising edge where both
// valid and ready are high. A stage may load whenever it is empty or its
// contents leave in the same cycle, so ready_o = !s1_valid | s2_ready and
// s2_ready = !s2_valid | ready_i; a full pipe streams one beat per cycle.
// The producer holds its payload while valid is high and ready is low.
module fp_32_to_16_convert_stream
  import fp_convert_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [FP32_W-1:0] operand_fp32_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [FP16_W-1:0] result_o,
  output logic [3:0]        status_o
);

  // ---------------- handshake ----------------
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s2_ready;
  logic s1_load, s2_load;

  assign s2_ready   = ~s2_valid_q | ready_i;
  assign ready_o    = ~s1_valid_q | s2_ready;
  assign s1_load    = valid_i & ready_o;
  assign s2_load    = s1_valid_q & s2_ready;
  assign s1_valid_d = ready_o  ? valid_i    : s1_valid_q;
  assign s2_valid_d = s2_ready ? s1_valid_q : s2_valid_q;

  // ---------------- stage 1: unpack / classify / align ----------------
  logic                  op_sign;
  logic [FP32_EXP_W-1:0] op_exp;
  logic [FP32_MAN_W-1:0] op_mant;
  logic signed [9:0]     e16;
  logic [9:0]            sh_amt;
  logic [24:0]           sh_out;
  logic                  sh_sticky;
  logic                  unused_sh_hi;
  s1_data_t              s1_d, s1_q;

  assign op_sign = operand_fp32_i[31];
  assign op_exp  = operand_fp32_i[30:23];
  assign op_mant = operand_fp32_i[22:0];
  assign e16     = $signed({2'b00, op_exp}) - $signed(10'(BIAS_DELTA));
  // (1 - e16) + 13; only meaningful on the tiny path where e16 <= 0.
  assign sh_amt  = 10'd14 - $unsigned(e16);

  // {hidden, mant, 0}: the appended zero lands the guard bit in sh_out[0].
  // Minimum shift is 14, so only sh_out[10:1] can carry mantissa bits.
  fp_shift_sticky #(
    .WIDTH(25),
    .SHW  (10)
  ) u_shift (
    .data_i  ({1'b1, op_mant, 1'b0}),
    .shamt_i (sh_amt),
    .data_o  (sh_out),
    .sticky_o(sh_sticky)
  );

  assign unused_sh_hi = |sh_out[24:11];

  always_comb begin
    s1_d      = '0;
    s1_d.sign = op_sign;
    if (op_exp == '1) begin
      s1_d.bypass = 1'b1;
      if (op_mant == '0) begin
        s1_d.bypass_res = {op_sign, FP16_INF_MAG};
      end else begin
        s1_d.bypass_res            = FP16_CANON_NAN;
        s1_d.bypass_status.invalid = ~op_mant[22];
      end
    end else if (op_exp == '0) begin
      // fp32 zeros and subnormals are far below binary16 range.
      s1_d.bypass     = 1'b1;
      s1_d.bypass_res = {op_sign, 15'd0};
      if (op_mant != '0) begin
        s1_d.bypass_status.underflow = 1'b1;
        s1_d.bypass_status.inexact   = 1'b1;
      end
    end else if (e16 >= 10'sd31) begin
      s1_d.bypass                 = 1'b1;
      s1_d.bypass_res             = {op_sign, FP16_INF_MAG};
      s1_d.bypass_status.overflow = 1'b1;
      s1_d.bypass_status.inexact  = 1'b1;
    end else if (e16 <= 10'sd0) begin
      s1_d.tiny   = 1'b1;
      s1_d.exp    = '0;
      s1_d.mant   = sh_out[10:1];
      s1_d.guard  = sh_out[0];
      s1_d.sticky = sh_sticky;
    end else begin
      s1_d.exp    = e16[4:0];
      s1_d.mant   = op_mant[22:13];
      s1_d.guard  = op_mant[12];
      s1_d.sticky = |op_mant[11:0];
    end
  end

  // ---------------- stage 2: round / pack ----------------
  logic                    round_up;
  logic                    inexact;
  logic [FP16_W-2:0]       rounded;
  logic [FP16_W-1:0]       result_d, result_q;
  status_t                 status_d, status_q;

  assign round_up = s1_q.guard & (s1_q.sticky | s1_q.mant[0]);
  assign inexact  = s1_q.guard | s1_q.sticky;
  // Exponent and mantissa added as one field: a mantissa carry bumps the
  // exponent, taking 0x3FF subnormals to min normal and 0x7BFF+ to infinity.
  assign rounded  = {s1_q.exp, s1_q.mant} + 15'(round_up);

  always_comb begin
    result_d = '0;
    status_d = '0;
    if (s1_q.bypass) begin
      result_d = s1_q.bypass_res;
      status_d = s1_q.bypass_status;
    end else if (rounded[14:10] == 5'd31) begin
      result_d         = {s1_q.sign, FP16_INF_MAG};
      status_d.overflow = 1'b1;
      status_d.inexact  = 1'b1;
    end else begin
      result_d          = {s1_q.sign, rounded};
      status_d.underflow = s1_q.tiny & inexact;
      status_d.inexact   = inexact;
    end
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      result_q   <= '0;
      status_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (s1_load) s1_q <= s1_d;
      if (s2_load) begin
        result_q <= result_d;
        status_q <= status_d;
      end
    end
  end

  assign valid_o  = s2_valid_q;
  assign result_o = result_q;
  assign status_o = status_q;

endmodule

// File: tb/tb_fp_32_to_16_convert_stream.sv
`timescale 1ns/1ps
module tb_fp_32_to_16_convert_stream;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_32_to_16_convert_stream_if bus (.clk_i(clk));

  fp_32_to_16_convert_stream dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .valid_i       (bus.in_valid),
    .ready_o       (bus.in_ready),
    .operand_fp32_i(bus.operand),
    .valid_o       (bus.out_valid),
    .ready_i       (bus.out_ready),
    .result_o      (bus.result),
    .status_o      (bus.status)
  );

  // ---------------- scoreboard state ----------------
  logic [19:0] exp_q[$];      // {result, status}
  logic [51:0] in_q[$];       // {operand, result, status}
  logic [19:0] cur_exp;
  int tests = 0;
  int fails = 0;
  int acc_cnt = 0;
  int out_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [31:0] op, input logic [15:0] r, input logic [3:0] s);
    in_q.push_back({op, r, s});
  endtask

  // Inputs change only here: 2 time units after a rising edge.
  task automatic drive_slot();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_acc(input int target, input int budget);
    int n = 0;
    while (acc_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 32'(acc_cnt >= target), 32'd1);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((in_q.size() != 0 || exp_q.size() != 0 || bus.in_valid || bus.out_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- driver ----------------
  // The handshake is evaluated on the falling edge, where valid and ready
  // hold the values the DUT will sample on the next rising edge.
  initial begin
    logic [51:0] item;
    logic        will_accept;
    forever begin
      @(negedge clk);
      will_accept = rst_n && bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      if (will_accept) begin
        exp_q.push_back(cur_exp);
        acc_cnt++;
        bus.in_valid = 1'b0;
      end
      if (!bus.in_valid && in_q.size() != 0) begin
        item         = in_q.pop_front();
        bus.operand  = item[51:20];
        cur_exp      = item[19:0];
        bus.in_valid = 1'b1;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [19:0] e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      out_cnt++;
      check("output_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("result", 32'(bus.result), 32'(e[19:4]));
        check("status", 32'(bus.status), 32'(e[3:0]));
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  logic [31:0] vec_op  [16];
  logic [15:0] vec_res [16];
  logic [3:0]  vec_st  [16];

  initial begin
    int a0;
    int o0;
    int n;

    vec_op  = '{32'h3F800000, 32'h3F801000, 32'h3F803000, 32'h477FE000,
                32'h477FF000, 32'h33800000, 32'h33000000, 32'h33000001,
                32'h00000001, 32'hFF800000, 32'h7F800001, 32'hFFC00000,
                32'h80000000, 32'h387FE000, 32'h7F7FFFFF, 32'hC0000000};
    vec_res = '{16'h3C00, 16'h3C00, 16'h3C02, 16'h7BFF,
                16'h7C00, 16'h0001, 16'h0000, 16'h0001,
                16'h0000, 16'hFC00, 16'h7E00, 16'h7E00,
                16'h8000, 16'h0400, 16'h7C00, 16'hC000};
    vec_st  = '{4'h0, 4'h1, 4'h1, 4'h0,
                4'h5, 4'h0, 4'h3, 4'h3,
                4'h3, 4'h0, 4'h8, 4'h0,
                4'h0, 4'h3, 4'h5, 4'h0};

    bus.in_valid  = 1'b0;
    bus.operand   = '0;
    bus.out_ready = 1'b0;
    cur_exp       = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_valid_o", 32'(bus.out_valid), 32'd0);
    check("rst_ready_o", 32'(bus.in_ready), 32'd1);
    check("rst_result_o", 32'(bus.result), 32'd0);
    check("rst_status_o", 32'(bus.status), 32'd0);

    drive_slot();
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;

    // Latency: accepted on edge A, valid_o rises on edge A+1.
    a0 = acc_cnt;
    push(32'h3F800000, 16'h3C00, 4'h0);
    wait_acc(a0 + 1, 10);
    check("lat_cycle1_valid_o", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("lat_cycle2_valid_o", 32'(bus.out_valid), 32'd1);
    check("lat_result_o", 32'(bus.result), 32'h3C00);
    check("lat_status_o", 32'(bus.status), 32'h0);
    drain(20);

    // Full directed table, streaming back-to-back.
    for (int i = 0; i < 16; i++) push(vec_op[i], vec_res[i], vec_st[i]);
    drain(100);

    // Same table with random downstream stalls.
    for (int i = 0; i < 16; i++) push(vec_op[i], vec_res[i], vec_st[i]);
    n = 0;
    while ((in_q.size() != 0 || exp_q.size() != 0) && n < 400) begin
      drive_slot();
      bus.out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    drive_slot();
    bus.out_ready = 1'b1;
    drain(50);

    // Backpressure: four back-to-back operands against a stalled sink.
    drive_slot();
    bus.out_ready = 1'b0;
    a0 = acc_cnt;
    o0 = out_cnt;
    push(32'h3F800000, 16'h3C00, 4'h0);
    push(32'h40000000, 16'h4000, 4'h0);
    push(32'hC0000000, 16'hC000, 4'h0);
    push(32'h3F803000, 16'h3C02, 4'h1);
    repeat (6) @(negedge clk);
    check("bp_accepted", 32'(acc_cnt - a0), 32'd2);
    check("bp_ready_o", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_valid_o", 32'(bus.out_valid), 32'd1);
      check("bp_hold_result_o", 32'(bus.result), 32'h3C00);
      check("bp_hold_status_o", 32'(bus.status), 32'h0);
      @(negedge clk);
    end
    drive_slot();
    bus.out_ready = 1'b1;
    drain(50);
    check("bp_emerged", 32'(out_cnt - o0), 32'd4);

    // Reset with both stages full.
    drive_slot();
    bus.out_ready = 1'b0;
    a0 = acc_cnt;
    push(32'h477FE000, 16'h7BFF, 4'h0);
    push(32'h3F801000, 16'h3C00, 4'h1);
    wait_acc(a0 + 2, 10);
    check("full_valid_o", 32'(bus.out_valid), 32'd1);
    check("full_ready_o", 32'(bus.in_ready), 32'd0);
    drive_slot();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst_valid_o", 32'(bus.out_valid), 32'd0);
    check("midrst_ready_o", 32'(bus.in_ready), 32'd1);
    check("midrst_result_o", 32'(bus.result), 32'd0);
    check("midrst_status_o", 32'(bus.status), 32'd0);
    exp_q.delete();
    drive_slot();
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    o0 = out_cnt;
    repeat (6) @(negedge clk);
    check("post_rst_no_stale", 32'(out_cnt - o0), 32'd0);
    check("post_rst_valid_o", 32'(bus.out_valid), 32'd0);

    // Pipeline still works after the mid-stream reset.
    push(32'hFF800000, 16'hFC00, 4'h0);
    drain(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fp_32_to_16_convert_stream.md
FP_32_TO_16_CONVERT_STREAM -- requirements
Module: fp_32_to_16_convert_stream

Interface
REQ-001 SHALL have port clk_i, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_ni, input, 1, synchronous active-low reset.
REQ-003 SHALL have port valid_i, input, 1, upstream operand valid.
REQ-004 SHALL have port ready_o, output, 1, block accepts operand this cycle.
REQ-005 SHALL have port operand_fp32_i, input, 32, IEEE-754 binary32 operand.
REQ-006 SHALL have port valid_o, output, 1, result valid.
REQ-007 SHALL have port ready_i, input, 1, downstream accepts result.
REQ-008 SHALL have port result_o, output, 16, IEEE-754 binary16 result.
REQ-009 SHALL have port status_o, output, 4, flags {invalid, overflow, underflow, inexact}, aligned with result_o.

Function
REQ-010 SHALL be a 2-stage pipeline: S1 unpack/classify/align, S2 round/pack; latency 2 cycles from accepted input to valid_o with ready_i high; throughput 1 per cycle.
REQ-011 SHALL transfer on valid&ready at each boundary; ready_o = !s1_valid | s2_ready, s2_ready = !s2_valid | ready_i (combinational, no bubble).
REQ-012 SHALL hold result_o, status_o, valid_o stable while valid_o=1 and ready_i=0; no drops, no duplicates, order preserved.
REQ-013 SHALL keep each stage's data register unchanged when that stage is not loaded (valid bits only gate).
REQ-014 SHALL rebias exponent: e16 = e32 - 112, computed signed 10-bit.
REQ-015 SHALL, for 1 <= e16 <= 30, form mantissa from fp32 mant[22:13], guard = mant[12], sticky = OR(mant[11:0]).
REQ-016 SHALL, for e16 <= 0, shift {1,mant} right by (1 - e16) + 13; shift amounts >= 25 SHALL yield zero mantissa with sticky = OR of all shifted-out bits.
REQ-017 SHALL round to nearest, ties to even; mantissa carry-out increments exponent (subnormal->min normal, 65504-range->infinity).
REQ-018 SHALL output signed infinity with overflow+inexact when rounded e16 >= 31.
REQ-019 SHALL set underflow when result is tiny (before rounding, e16 <= 0) and inexact; inexact whenever guard|sticky nonzero.
REQ-020 SHALL map fp32 zero to signed zero; fp32 subnormals to signed zero with underflow+inexact.
REQ-021 SHALL map fp32 infinity to signed fp16 infinity, no flags.
REQ-022 SHALL map any NaN to canonical 0x7E00; invalid set only for signalling NaN (mant[22]=0, mant nonzero).

Reset
REQ-023 SHALL, on rst_ni=0 at a clock edge, clear both stage valid bits: valid_o=0 next cycle; ready_o=1 while reset is held.
REQ-024 SHALL discard in-flight operands when reset asserts mid-operation; result_o/status_o SHALL reset to 0.

Structure
REQ-025 SHALL take FP16/FP32 widths, biases (15, 127), bias delta 112, canonical NaN 0x7E00 and a packed status-flag struct from shared package fp_convert_pkg.
REQ-026 SHALL instantiate one sub-module fp_shift_sticky (parameterised width, right shift with sticky OR) for the subnormal path.

Verification
REQ-027 SHALL check 0x3F800000 -> 0x3C00, flags 0, valid_o exactly 2 cycles after acceptance.
REQ-028 SHALL check rounding: 0x3F801000 -> 0x3C00 inexact; 0x3F803000 -> 0x3C02 inexact; 0x477FE000 -> 0x7BFF; 0x477FF000 -> 0x7C00 overflow+inexact.
REQ-029 SHALL check subnormals: 0x33800000 -> 0x0001 no flags; 0x33000000 -> 0x0000 underflow+inexact; 0x33000001 -> 0x0001 underflow+inexact; 0x00000001 -> 0x0000 underflow+inexact.
REQ-030 SHALL check specials: 0xFF800000 -> 0xFC00; 0x7F800001 -> 0x7E00 invalid; 0xFFC00000 -> 0x7E00 no flags; 0x80000000 -> 0x8000.
REQ-031 SHALL check backpressure: 4 back-to-back inputs, ready_i low 3 cycles -> exactly 2 accepted, ready_o low, output stable, all 4 emerge in order once released.
REQ-032 SHALL check reset with both stages full -> valid_o=0 next cycle, no stale result after rst_ni deasserts.
